// File: rtl/timer_pkg.sv
// Shared constants and FSM state encoding for the down_timer block.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer client (master) and down_timer (slave).
interface down_timer_if #(
  parameter int unsigned WIDTH = timer_pkg::TIMER_WIDTH
) ();

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             expired;

  modport master (
    output data_in, load, enable, auto_reload,
    input  count, tc, busy, expired
  );

  modport slave (
    input  data_in, load, enable, auto_reload,
    output count, tc, busy, expired
  );

endinterface

// File: rtl/down_timer.sv
// Loadable down counter with one-shot / auto-reload terminal-count behaviour.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input logic         clk,
  input logic         rst,
  down_timer_if.slave bus
);

  timer_state_e     state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             tc_q, tc_n;

  // State, counter, reload value and terminal-count pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      tc_q     <= tc_n;
    end
  end

  // Next-state: load beats counting; only RUN decrements.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    tc_n     = 1'b0;

    if (bus.load) begin
      count_n  = bus.data_in;
      reload_n = bus.data_in;
      state_n  = (bus.data_in != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.enable) begin
      if (count_q == WIDTH'(1)) begin
        // Terminal cycle: auto_reload matters only here.
        tc_n = 1'b1;
        if (bus.auto_reload) begin
          count_n = reload_q;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
      end else begin
        count_n = count_q - WIDTH'(1);
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.expired = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: directed vectors push expectations, a monitor checks each cycle.
module tb_down_timer;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         expired;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: every cycle the DUT presents a fresh registered state; compare against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_total++;
        if (bus.count === e.count && bus.tc === e.tc &&
            bus.busy === e.busy && bus.expired === e.expired) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got count=%02h tc=%b busy=%b expired=%b, want count=%02h tc=%b busy=%b expired=%b",
                   e.name, bus.count, bus.tc, bus.busy, bus.expired,
                   e.count, e.tc, e.busy, e.expired);
        end
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must be after the edge.
  task automatic step(input logic r, input logic ld, input logic [W-1:0] d,
                      input logic en, input logic ar,
                      input logic [W-1:0] ec, input logic etc, input logic eb,
                      input logic ee, input string nm);
    exp_t e;
    rst             = r;
    bus.load        = ld;
    bus.data_in     = d;
    bus.enable      = en;
    bus.auto_reload = ar;
    e.count   = ec;
    e.tc      = etc;
    e.busy    = eb;
    e.expired = ee;
    e.name    = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.load        = 1'b1;
    bus.data_in     = 8'h55;
    bus.enable      = 1'b0;
    bus.auto_reload = 1'b0;

    // Reset overrides a simultaneous load.
    step(1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, "reset0");
    step(1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0, "reset1");

    // One-shot countdown from 3.
    step(0, 1, 8'h03, 1, 0, 8'h03, 0, 1, 0, "os_load");
    step(0, 0, 8'h00, 1, 0, 8'h02, 0, 1, 0, "os_2");
    step(0, 0, 8'h00, 1, 0, 8'h01, 0, 1, 0, "os_1");
    step(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 1, "os_tc");
    for (int i = 0; i < 10; i++)
      step(0, 0, 8'h00, 1, logic'(i % 2), 8'h00, 0, 0, 1, "os_done_hold");

    // Auto-reload from 2.
    step(0, 1, 8'h02, 0, 1, 8'h02, 0, 1, 0, "ar_load");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 1, 1, 8'h01, 0, 1, 0, "ar_dec");
      step(0, 0, 8'h00, 1, 1, 8'h02, 1, 1, 0, "ar_reload");
    end
    step(0, 0, 8'h00, 0, 1, 8'h02, 0, 1, 0, "ar_hold");
    step(0, 0, 8'h00, 1, 0, 8'h01, 0, 1, 0, "ar_nonterm_ar0");
    step(0, 0, 8'h00, 1, 1, 8'h02, 1, 1, 0, "ar_term_ar1");

    // Reload value of 1: tc every enabled cycle.
    step(0, 1, 8'h01, 0, 1, 8'h01, 0, 1, 0, "r1_load");
    for (int i = 0; i < 3; i++)
      step(0, 0, 8'h00, 1, 1, 8'h01, 1, 1, 0, "r1_tc");
    step(0, 0, 8'h00, 0, 1, 8'h01, 0, 1, 0, "r1_hold");

    // Enable gaps, then load colliding with a terminal event.
    step(0, 1, 8'h04, 0, 0, 8'h04, 0, 1, 0, "gap_load");
    step(0, 0, 8'h00, 1, 0, 8'h03, 0, 1, 0, "gap_en1");
    step(0, 0, 8'h00, 0, 0, 8'h03, 0, 1, 0, "gap_en0");
    step(0, 0, 8'h00, 1, 0, 8'h02, 0, 1, 0, "gap_en1b");
    step(0, 0, 8'h00, 0, 0, 8'h02, 0, 1, 0, "gap_en0b");
    step(0, 0, 8'h00, 1, 0, 8'h01, 0, 1, 0, "gap_to1");
    step(0, 1, 8'h09, 1, 0, 8'h09, 0, 1, 0, "collide_load");
    step(0, 0, 8'h00, 0, 0, 8'h09, 0, 1, 0, "collide_hold");

    // Zero load goes idle and never expires.
    step(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, "zero_load");
    for (int i = 0; i < 5; i++)
      step(0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, "zero_en");

    // Mid-run reset, then a load of 1.
    step(0, 1, 8'hFF, 0, 0, 8'hFF, 0, 1, 0, "mr_load");
    for (int i = 1; i <= 10; i++)
      step(0, 0, 8'h00, 1, 0, 8'(8'hFF - i), 0, 1, 0, "mr_dec");
    step(1, 1, 8'h07, 1, 0, 8'h00, 0, 0, 0, "mr_reset");
    step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "mr_idle");
    step(0, 1, 8'h01, 0, 0, 8'h01, 0, 1, 0, "mr_load1");
    step(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 1, "mr_tc");
    step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, "mr_done");

    // Monitor must have drained every expectation.
    repeat (2) @(posedge clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
